iir_out_capture: RTL and testbench
==================================

Name: iir_out_capture

Overview:
- Output-side sink for the IIR filter chain: consumes the 24-bit `data_out`/`data_valid_out` stream of the filter top.
- Captures up to DEPTH consecutive valid samples into an internal buffer and accumulates run statistics (count, peak magnitude, clip count, overrun).
- Exposes a synchronous read port so a host or bench drains the captured response after the run.
- Mirror of the stimulus side: the stimulus side writes samples into the filter, this block reads them out.

Parameters:
- DW, 24, sample width (signed two's complement).
- DEPTH, 2048, capture buffer depth in samples.
- AW, 11, address width; must satisfy 2^AW = DEPTH.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- arm  input  1  single-cycle pulse; clears statistics and starts a capture.
- stop  input  1  single-cycle pulse; ends the capture early.
- data_in  input  DW  signed sample from the filter output.
- data_valid_in  input  1  sample strobe, one sample per asserted cycle.
- rd_en  input  1  read request.
- rd_addr  input  AW  read address.
- rd_data  output  DW  read result.
- rd_valid  output  1  rd_data qualifier.
- capturing  output  1  high in CAPTURE state.
- done  output  1  high in DONE state.
- capture_count  output  AW+1  number of samples stored (0..DEPTH).
- peak_abs  output  DW  maximum |sample| captured, unsigned.
- clip_cnt  output  16  number of captured samples equal to +(2^(DW-1)-1) or -2^(DW-1); saturates at 0xFFFF.
- overrun  output  1  sticky; a valid sample arrived while in DONE.

Behaviour:
- Reset, asynchronous, any state: state=IDLE; all outputs 0; write pointer 0. Buffer contents are not reset. Reset mid-capture abandons the run.
- States:
  - IDLE: arm -> CAPTURE.
  - CAPTURE: stop, or the write of the DEPTH-th sample -> DONE.
  - DONE: arm -> CAPTURE.
- arm (IDLE or DONE): next cycle capture_count=0, peak_abs=0, clip_cnt=0, overrun=0, write pointer=0. A data_valid_in in the same cycle as arm is not captured and does not set overrun. arm during CAPTURE is ignored.
- CAPTURE, data_valid_in=1:
  - mem[ptr]<=data_in; ptr++; capture_count++.
  - peak_abs<=max(peak_abs,|data_in|). |-2^(DW-1)| = 2^(DW-1), representable unsigned.
  - clip_cnt increments on full-scale values.
  - All updates are visible the cycle after the strobe.
- Final slot: valid with capture_count=DEPTH-1 writes the sample; capture_count=DEPTH; state=DONE next cycle. No wrap-around, never overwrites.
- stop in CAPTURE: a sample valid in the same cycle is still captured; DONE next cycle. stop in IDLE/DONE is ignored.
- IDLE, data_valid_in: dropped silently.
- DONE, data_valid_in: dropped; overrun<=1 (sticky until arm or reset).
- Continuous valid every cycle is accepted without stall; there is no backpressure.
- Read port:
  - rd_en at cycle t -> rd_data and rd_valid=1 at t+1. rd_valid=0 otherwise; rd_data holds its last value when rd_valid=0.
  - rd_data=0 when rd_addr >= capture_count, with capture_count sampled at t.
  - Reads are legal in any state.
  - Same-address read and write in one cycle returns the old memory word, but addr >= count forces 0 anyway.
- Buffer is a single-write, single-read synchronous RAM, inferable as block RAM.

Test Plan:
- Reset then arm, 2048 valid samples = ramp 0..2047 -> done=1 one cycle after the last sample; capture_count=2048; peak_abs=2047; clip_cnt=0; read addr 5 returns 5 one cycle later with rd_valid=1.
- Arm, samples {100, -8388608, 8388607, -3} then stop -> capture_count=4; peak_abs=8388608; clip_cnt=2; addr 1 reads 0x800000; addr 4 reads 0.
- After DONE, 3 extra valids -> overrun=1, capture_count unchanged; then arm with a valid in the same cycle -> overrun=0, capture_count=0, that sample not stored.
- stop and valid (value 77) in the same cycle after 10 samples -> capture_count=11; addr 10 reads 77; arm pulses during CAPTURE have no effect.
- Drive rst_n low after 500 captured samples -> all outputs 0 immediately, state IDLE; subsequent valids without arm are ignored (capture_count stays 0).
- Back-to-back rd_en over addrs 0..7 every cycle -> 8 consecutive rd_valid cycles, each rd_data matching the stored value of the previous cycle's address.

Source files
------------

// File: rtl/iir_out_capture.sv
// Output-side capture sink for the IIR filter chain: stores up to DEPTH valid
// samples, tracks run statistics and offers a synchronous read-back port.
module iir_out_capture #(
  parameter int DW    = 24,
  parameter int DEPTH = 2048,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          arm,
  input  logic          stop,
  input  logic [DW-1:0] data_in,
  input  logic          data_valid_in,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          capturing,
  output logic          done,
  output logic [AW:0]   capture_count,
  output logic [DW-1:0] peak_abs,
  output logic [15:0]   clip_cnt,
  output logic          overrun
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_LAST = (AW+1)'(DEPTH - 1);
  localparam logic [DW-1:0] POS_FS   = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] NEG_FS   = {1'b1, {(DW-1){1'b0}}};

  logic [1:0]    state;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] mem_q;
  logic          zero_q;
  logic [DW-1:0] mag;
  logic          full_scale;
  logic          wr_en;

  // Two's complement negate; the most negative value maps to 2^(DW-1) unsigned.
  assign mag        = data_in[DW-1] ? ('0 - data_in) : data_in;
  assign full_scale = (data_in == POS_FS) || (data_in == NEG_FS);
  assign wr_en      = (state == CAPTURE) && data_valid_in;

  assign capturing = (state == CAPTURE);
  assign done      = (state == DONE);
  assign rd_data   = zero_q ? '0 : mem_q;

  // Block RAM: no reset, read-first so a colliding read sees the old word.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[capture_count[AW-1:0]] <= data_in;
    if (rd_en)
      mem_q <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      rd_valid <= rd_en;
      if (rd_en)
        zero_q <= ({1'b0, rd_addr} >= capture_count);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      capture_count <= '0;
      peak_abs      <= '0;
      clip_cnt      <= '0;
      overrun       <= 1'b0;
    end else begin
      case (state)
        CAPTURE: begin
          if (data_valid_in) begin
            capture_count <= capture_count + CNT_ONE;
            if (mag > peak_abs)
              peak_abs <= mag;
            if (full_scale && (clip_cnt != 16'hFFFF))
              clip_cnt <= clip_cnt + 16'd1;
          end
          if (stop || (data_valid_in && (capture_count == CNT_LAST)))
            state <= DONE;
        end
        IDLE, DONE: begin
          if (arm) begin
            state         <= CAPTURE;
            capture_count <= '0;
            peak_abs      <= '0;
            clip_cnt      <= '0;
            overrun       <= 1'b0;
          end else if ((state == DONE) && data_valid_in) begin
            overrun <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_out_capture.sv
// Directed bench for iir_out_capture: a behavioural capture model checked every
// cycle, plus literal expectations at key points of each scenario.
module tb_iir_out_capture;

  localparam int DW    = 24;
  localparam int DEPTH = 2048;
  localparam int AW    = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arm = 1'b0;
  logic          stop = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          data_valid_in = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          capturing;
  logic          done;
  logic [AW:0]   capture_count;
  logic [DW-1:0] peak_abs;
  logic [15:0]   clip_cnt;
  logic          overrun;

  int total = 0;
  int bad   = 0;

  iir_out_capture #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .stop(stop),
    .data_in(data_in), .data_valid_in(data_valid_in),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .capturing(capturing), .done(done), .capture_count(capture_count),
    .peak_abs(peak_abs), .clip_cnt(clip_cnt), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Behavioural model: a list of stored samples plus run flags.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_count;
  logic          m_cap, m_done, m_ovr, m_rv;
  logic [DW-1:0] m_peak, m_rd;
  int            m_clip;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cap = 0; m_done = 0; m_ovr = 0; m_rv = 0;
      m_count = 0; m_peak = '0; m_clip = 0; m_rd = '0;
    end else begin
      m_rv = rd_en;
      if (rd_en)
        m_rd = (int'(rd_addr) < m_count) ? m_mem[rd_addr] : '0;
      if (m_cap) begin
        if (data_valid_in) begin
          int v;
          v = data_in[DW-1] ? int'(data_in) - (1 << DW) : int'(data_in);
          m_mem[m_count] = data_in;
          m_count++;
          if (v < 0) v = -v;
          if (v > int'(m_peak)) m_peak = DW'(v);
          if ((v == (1 << (DW-1))) || (v == (1 << (DW-1)) - 1))
            m_clip = (m_clip < 65535) ? m_clip + 1 : 65535;
        end
        if (stop || m_count == DEPTH) begin
          m_cap = 0; m_done = 1;
        end
      end else if (arm) begin
        m_cap = 1; m_done = 0; m_ovr = 0;
        m_count = 0; m_peak = '0; m_clip = 0;
      end else if (m_done && data_valid_in) begin
        m_ovr = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("capturing", 32'(capturing), 32'(m_cap));
      check("done", 32'(done), 32'(m_done));
      check("count", 32'(capture_count), 32'(m_count));
      check("peak", 32'(peak_abs), 32'(m_peak));
      check("clip", 32'(clip_cnt), 32'(m_clip));
      check("overrun", 32'(overrun), 32'(m_ovr));
      check("rd_valid", 32'(rd_valid), 32'(m_rv));
      check("rd_data", 32'(rd_data), 32'(m_rd));
    end
  end

  task automatic drive(input logic a, input logic s, input logic v, input logic [DW-1:0] d,
                       input logic re, input logic [AW-1:0] ra);
    @(negedge clk);
    arm = a; stop = s; data_valid_in = v; data_in = d; rd_en = re; rd_addr = ra;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic sample(input logic [DW-1:0] d);
    drive(1'b0, 1'b0, 1'b1, d, 1'b0, '0);
  endtask

  task automatic read(input logic [AW-1:0] a);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1, a);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_count", 32'(capture_count), 32'd0);
    check("reset_rd_data", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
    idle();

    // Full ramp capture
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < DEPTH; i++) sample(DW'(i));
    idle();
    check("ramp_done", 32'(done), 32'd1);
    check("ramp_count", 32'(capture_count), 32'd2048);
    check("ramp_peak", 32'(peak_abs), 32'd2047);
    check("ramp_clip", 32'(clip_cnt), 32'd0);
    read(11'd5);
    idle();
    check("ramp_rd5_valid", 32'(rd_valid), 32'd1);
    check("ramp_rd5", 32'(rd_data), 32'd5);

    // Full-scale samples then stop
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    sample(24'd100);
    sample(24'h800000);
    sample(24'h7FFFFF);
    sample(24'hFFFFFD);
    drive(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
    idle();
    check("fs_count", 32'(capture_count), 32'd4);
    check("fs_peak", 32'(peak_abs), 32'd8388608);
    check("fs_clip", 32'(clip_cnt), 32'd2);
    read(11'd1);
    idle();
    check("fs_rd1", 32'(rd_data), 32'h800000);
    read(11'd4);
    idle();
    check("fs_rd4", 32'(rd_data), 32'd0);

    // Overrun in DONE, then arm with a coincident valid
    repeat (3) sample(24'd9);
    idle();
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_count", 32'(capture_count), 32'd4);
    drive(1'b1, 1'b0, 1'b1, 24'd555, 1'b0, '0);
    idle();
    check("arm_ovr_clear", 32'(overrun), 32'd0);
    check("arm_count", 32'(capture_count), 32'd0);
    check("arm_capturing", 32'(capturing), 32'd1);
    drive(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
    read(11'd0);
    idle();
    check("arm_rd0", 32'(rd_data), 32'd0);

    // Stop with a coincident sample; arm during capture is ignored
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 10; i++)
      drive((i == 3) || (i == 7), 1'b0, 1'b1, DW'(1000 + i), 1'b0, '0);
    drive(1'b0, 1'b1, 1'b1, 24'd77, 1'b0, '0);
    idle();
    check("stop_count", 32'(capture_count), 32'd11);
    check("stop_done", 32'(done), 32'd1);
    read(11'd10);
    idle();
    check("stop_rd10", 32'(rd_data), 32'd77);

    // Back-to-back reads
    for (int i = 0; i < 9; i++) begin
      if (i < 8) read(AW'(i));
      else idle();
      if (i > 0) begin
        check("b2b_valid", 32'(rd_valid), 32'd1);
        check("b2b_data", 32'(rd_data), 32'(1000 + i - 1));
      end
    end
    idle();

    // Reset mid-capture
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 500; i++) sample(DW'(i * 3));
    read(11'd2);
    #2 rst_n = 1'b0;
    #1;
    check("rst_capturing", 32'(capturing), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_count", 32'(capture_count), 32'd0);
    check("rst_peak", 32'(peak_abs), 32'd0);
    check("rst_clip", 32'(clip_cnt), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    idle();
    rst_n = 1'b1;
    repeat (5) sample(24'd42);
    idle();
    check("post_rst_count", 32'(capture_count), 32'd0);
    check("post_rst_capturing", 32'(capturing), 32'd0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
